// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one booth_multiplier between NREQ requesters.
// It latches the winner's operands, starts the multiplier, and returns the product or a timeout error.
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    mult_start,
  output logic [WIDTH-1:0]        mult_a,
  output logic [WIDTH-1:0]        mult_b,
  input  logic [2*WIDTH-1:0]      mult_product,
  input  logic                    mult_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     id;
  logic [IW-1:0]     pick_id;
  logic              pick_found;
  logic [WIDTH-1:0]  pick_a;
  logic [WIDTH-1:0]  pick_b;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              timeout_hit;
  logic [NREQ-1:0]   id_onehot;

  // Two descending passes: the second (indices at or above ptr) overrides the
  // first, so the lowest set bit at/above ptr wins, else the lowest below it.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_a     = '0;
    pick_b     = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && (IW'(j) < ptr)) begin
        pick_found = 1'b1;
        pick_id    = IW'(j);
        pick_a     = req_a[j*WIDTH +: WIDTH];
        pick_b     = req_b[j*WIDTH +: WIDTH];
      end
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && (IW'(j) >= ptr)) begin
        pick_found = 1'b1;
        pick_id    = IW'(j);
        pick_a     = req_a[j*WIDTH +: WIDTH];
        pick_b     = req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      id_onehot[j] = (id == IW'(j));
    end
  end

  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // mult_ready is deliberately not looked at in ISSUE: it may still be high from the last operation.
  always_comb begin
    state_next = state;
    gnt        = '0;
    resp_valid = '0;
    mult_start = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_found) state_next = ISSUE;
      end
      ISSUE: begin
        mult_start = 1'b1;
        gnt        = id_onehot;
        state_next = WAIT;
      end
      WAIT: begin
        if (mult_ready || timeout_hit) state_next = RESP;
      end
      RESP: begin
        resp_valid = id_onehot;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands load only in IDLE, so they stay stable from ISSUE through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      id           <= '0;
      cnt          <= '0;
      mult_a       <= '0;
      mult_b       <= '0;
      resp_product <= '0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            id     <= pick_id;
            mult_a <= pick_a;
            mult_b <= pick_b;
          end
        end
        ISSUE: begin
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (mult_ready) begin
            resp_product <= mult_product;
            resp_err     <= 1'b0;
          end else if (timeout_hit) begin
            resp_product <= '0;
            resp_err     <= 1'b1;
          end
        end
        RESP: begin
          ptr <= (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a small behavioural multiplier model.
// Table-driven single transactions plus hand-written multi-cycle sequences.
module tb_booth_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 31;
  localparam int LIMIT   = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  gnt;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_product;
  logic        resp_err;
  logic        busy;
  logic        mult_start;
  logic [3:0]  mult_a;
  logic [3:0]  mult_b;
  logic [7:0]  model_product = 8'h00;
  logic        model_ready   = 1'b1;

  int          model_delay = 1;
  logic        model_stuck = 1'b0;
  logic        model_pending = 1'b0;
  int          model_left = 0;
  logic [7:0]  model_result = 8'h00;
  int          op_a;
  int          op_b;

  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    int          delay;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_a;
    logic [3:0]  exp_b;
    logic [7:0]  exp_prod;
  } vec_t;

  vec_t vecs [7];

  booth_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .busy         (busy),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_product (model_product),
    .mult_ready   (model_ready)
  );

  always #5 clk = ~clk;

  // Multiplier model: ready stays stale through the start cycle, then goes
  // low and rises model_delay cycles after start unless stuck.
  always @(negedge clk) begin
    if (mult_start) begin
      model_pending = 1'b1;
      model_left    = model_delay;
      op_a          = $signed(mult_a);
      op_b          = $signed(mult_b);
      model_result  = 8'(op_a * op_b);
    end else if (model_pending) begin
      model_ready = 1'b0;
      model_left  = model_left - 1;
      if (model_left == 0 && !model_stuck) begin
        model_ready   = 1'b1;
        model_product = model_result;
        model_pending = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == 4'b0 && n < LIMIT);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (resp_valid == 4'b0 && n < LIMIT);
  endtask

  task automatic apply_stimulus(input string tag, input logic [3:0] r, input logic [15:0] a,
                                input logic [15:0] b, input int d, input logic [3:0] eg,
                                input logic [3:0] ea, input logic [3:0] eb,
                                input logic [7:0] ep, input logic ee, input int elat);
    int lat;
    model_delay = d;
    req   = r;
    req_a = a;
    req_b = b;
    wait_gnt(lat);
    check_output({tag, "_gnt_lat"}, lat, 1);
    check_output({tag, "_gnt"}, gnt, eg);
    check_output({tag, "_start"}, mult_start, 1);
    check_output({tag, "_busy"}, busy, 1);
    check_output({tag, "_mult_a"}, mult_a, ea);
    check_output({tag, "_mult_b"}, mult_b, eb);
    req = 4'b0;
    wait_resp(lat);
    check_output({tag, "_resp_lat"}, lat, elat);
    check_output({tag, "_resp_valid"}, resp_valid, eg);
    check_output({tag, "_product"}, resp_product, ep);
    check_output({tag, "_err"}, resp_err, ee);
    check_output({tag, "_a_stable"}, mult_a, ea);
    tick();
    check_output({tag, "_valid_pulse"}, resp_valid, 0);
    check_output({tag, "_product_held"}, resp_product, ep);
    check_output({tag, "_err_held"}, resp_err, ee);
    check_output({tag, "_idle"}, busy, 0);
  endtask

  // Requests held until granted; slice k of eg/ep is the k-th expected grant/product.
  task automatic apply_held(input string tag, input logic [3:0] r, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] eg, input logic [31:0] ep,
                            input int n, input int d);
    int lat;
    model_delay = d;
    req   = r;
    req_a = a;
    req_b = b;
    for (int k = 0; k < n; k++) begin
      wait_gnt(lat);
      check_output($sformatf("%s%0d_gnt_lat", tag, k), lat, (k == 0) ? 1 : 2);
      check_output($sformatf("%s%0d_gnt", tag, k), gnt, eg[k*4 +: 4]);
      check_output($sformatf("%s%0d_start", tag, k), mult_start, 1);
      req = req & ~eg[k*4 +: 4];
      wait_resp(lat);
      check_output($sformatf("%s%0d_resp_lat", tag, k), lat, d + 1);
      check_output($sformatf("%s%0d_resp_valid", tag, k), resp_valid, eg[k*4 +: 4]);
      check_output($sformatf("%s%0d_product", tag, k), resp_product, ep[k*8 +: 8]);
    end
    tick();
    check_output({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;

    vecs[0] = '{4'b0001, 16'h1238, 16'h4568, 5, 4'b0001, 4'h8, 4'h8, 8'h40};
    vecs[1] = '{4'b0100, 16'h9376, 16'h1E23, 2, 4'b0100, 4'h3, 4'hE, 8'hFA};
    vecs[2] = '{4'b1000, 16'h7123, 16'h7456, 1, 4'b1000, 4'h7, 4'h7, 8'h31};
    vecs[3] = '{4'b0010, 16'h4182, 16'h9970, 3, 4'b0010, 4'h8, 4'h7, 8'hC8};
    vecs[4] = '{4'b0001, 16'h000F, 16'h123F, 1, 4'b0001, 4'hF, 4'hF, 8'h01};
    vecs[5] = '{4'b1000, 16'h8000, 16'hF000, 6, 4'b1000, 4'h8, 4'hF, 8'h08};
    vecs[6] = '{4'b0100, 16'hF0FF, 16'h3B33, 2, 4'b0100, 4'h0, 4'hB, 8'h00};

    reset = 1'b0;
    req   = 4'b0;
    req_a = 16'h0;
    req_b = 16'h0;
    tick();
    tick();
    check_output("rst_gnt", gnt, 0);
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_resp_err", resp_err, 0);
    check_output("rst_start", mult_start, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_mult_a", mult_a, 0);
    check_output("rst_mult_b", mult_b, 0);
    check_output("rst_product", resp_product, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      apply_stimulus($sformatf("v%0d", i), vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].delay,
                     vecs[i].exp_gnt, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_prod,
                     1'b0, vecs[i].delay + 1);
    end

    apply_stimulus("stale", 4'b0010, 16'h0050, 16'h0030, 4, 4'b0010, 4'h5, 4'h3, 8'h0F, 1'b0, 5);
    apply_stimulus("edge", 4'b1000, 16'h2000, 16'h3000, TIMEOUT, 4'b1000, 4'h2, 4'h3,
                   8'h06, 1'b0, TIMEOUT + 1);

    model_stuck = 1'b1;
    apply_stimulus("tmo", 4'b0001, 16'h0006, 16'h0007, 1, 4'b0001, 4'h6, 4'h7,
                   8'h00, 1'b1, TIMEOUT + 1);

    model_delay = 1;
    req   = 4'b0100;
    req_a = 16'h0500;
    req_b = 16'h0500;
    wait_gnt(seen);
    check_output("midrst_gnt", gnt, 4'b0100);
    req = 4'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_gnt0", gnt, 0);
    check_output("midrst_start", mult_start, 0);
    check_output("midrst_mult_a", mult_a, 0);
    check_output("midrst_mult_b", mult_b, 0);
    check_output("midrst_product", resp_product, 0);
    check_output("midrst_err", resp_err, 0);
    check_output("midrst_valid", resp_valid, 0);
    tick();
    tick();
    reset = 1'b1;
    model_stuck = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid != 4'b0) seen++;
    end
    check_output("midrst_no_resp", seen, 0);

    apply_held("rr", 4'b1111, 16'h4321, 16'h2222, 16'h8421, 32'h08060402, 4, 1);
    apply_stimulus("r1", 4'b0010, 16'h0070, 16'h0030, 2, 4'b0010, 4'h7, 4'h3, 8'h15, 1'b0, 3);
    apply_held("wrap", 4'b0011, 16'h0065, 16'h00F2, 16'h0021, 32'h0000FA0A, 2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
